// File: rtl/wiphase_spi_pkg.sv
// Shared definitions for the SPI transaction arbiter: FSM states, default
// parameter values and a width helper.
package wiphase_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_RESP,
        ST_GAP
    } state_t;

    localparam int DEF_N_REQ      = 3;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_GAP_CYCLES = 4;
    localparam int DEF_TIMEOUT    = 1023;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int width_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Requester and SPI-master side signals of the arbiter; the arbiter uses the
// slave modport, the agents driving it use the master modport.
interface spi_arbiter_if
    import wiphase_spi_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W
);
    localparam int SEL_W = width_for(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    rsp_err;
    logic                    spi_start;
    logic [DATA_W-1:0]       spi_wdata;
    logic [SEL_W-1:0]        spi_sel;
    logic                    spi_done;
    logic [DATA_W-1:0]       spi_rdata;

    modport slave (
        input  req_valid, req_wdata, spi_done, spi_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, spi_start, spi_wdata, spi_sel
    );

    modport master (
        output req_valid, req_wdata, spi_done, spi_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, spi_start, spi_wdata, spi_sel
    );

endinterface

// File: rtl/spi_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or above ptr, wrapping.
module rr_picker
    import wiphase_spi_pkg::*;
#(
    parameter int  N_REQ = DEF_N_REQ,
    localparam int SEL_W = width_for(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant_idx,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic             found;
    int unsigned      sum;

    // Rotate so bit 0 is the requester at ptr; the first set bit wins.
    always_comb begin
        rot       = N_REQ'({req, req} >> ptr);
        found     = 1'b0;
        sum       = 0;
        grant_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && rot[i]) begin
                found     = 1'b1;
                sum       = 32'(ptr) + i;
                grant_idx = SEL_W'((sum >= N_REQ) ? sum - N_REQ : sum);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/spi_arbiter.sv
// Arbitrates N_REQ requesters onto one SPI master, one transaction at a time,
// with round-robin grants, a WAIT timeout and an idle gap between transactions.
module spi_arbiter
    import wiphase_spi_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic          mclk_i,
    input  logic          mclk_reset,
    input  logic          pll_locked,
    output logic          busy,
    spi_arbiter_if.slave  bus
);

    localparam int SEL_W   = width_for(N_REQ);
    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = width_for(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [SEL_W-1:0]  grant_idx;
    logic              any_req;
    logic              grant;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    assign grant = (state_q == ST_IDLE) && pll_locked && any_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (grant) begin
                    state_d = ST_START;
                    sel_d   = grant_idx;
                    ptr_d   = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        if (grant_idx == SEL_W'(i)) wdata_d = bus.req_wdata[i*DATA_W +: DATA_W];
                    end
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (bus.spi_done) begin
                    state_d = ST_RESP;
                    rdata_d = bus.spi_rdata;
                    err_d   = 1'b0;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = ST_RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                cnt_d   = '0;
                state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) state_d = ST_IDLE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge mclk_i or posedge mclk_reset) begin
        if (mclk_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // The accept pulse is combinational from IDLE, so it is gated by reset too.
    assign bus.req_ready = (grant && !mclk_reset) ? (N_REQ'(1) << grant_idx) : '0;
    assign bus.spi_start = (state_q == ST_START);
    assign bus.spi_wdata = wdata_q;
    assign bus.spi_sel   = sel_q;
    assign bus.rsp_valid = (state_q == ST_RESP) ? (N_REQ'(1) << sel_q) : '0;
    assign bus.rsp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
    assign bus.rsp_err   = (state_q == ST_RESP) && err_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_arbiter.sv
// Randomized and directed bench for spi_arbiter against a transaction-timeline model.
module tb_spi_arbiter;

    localparam int N   = 3;
    localparam int DW  = 16;
    localparam int GAP = 4;
    localparam int TO  = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pll = 1'b0;
    logic busy;

    spi_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    spi_arbiter #(.N_REQ(N), .DATA_W(DW), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .mclk_i     (clk),
        .mclk_reset (rst),
        .pll_locked (pll),
        .busy       (busy),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Model: each transaction is a timeline of cycle stamps.
    int          m_ptr = 0;
    int          m_start = -1;
    int          m_wait_lo = -1;
    int          m_resp = -1;
    int          m_free = 0;
    int          m_sel = 0;
    bit          pending = 1'b0;
    logic [DW-1:0] m_wdata, m_rdata;
    logic        m_err;
    logic [N-1:0] m_gmask;
    bit          e_idle;
    int          w;
    logic [N-1:0] e_ready, e_rv;

    initial begin
        m_gmask = '0;
        m_wdata = '0;
        m_rdata = '0;
        m_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_busy", busy, 0);
                chk("rst_req_ready", bus.req_ready, 0);
                chk("rst_rsp_valid", bus.rsp_valid, 0);
                chk("rst_rsp_rdata", bus.rsp_rdata, 0);
                chk("rst_rsp_err", bus.rsp_err, 0);
                chk("rst_spi_start", bus.spi_start, 0);
                chk("rst_spi_sel", bus.spi_sel, 0);
                chk("rst_spi_wdata", bus.spi_wdata, 0);
                m_ptr = 0; m_start = -1; m_wait_lo = -1; m_resp = -1; m_free = 0;
                pending = 1'b0; m_gmask = '0;
            end else begin
                e_idle = !pending && (cyc >= m_free);
                chk("busy", busy, !e_idle);
                chk("spi_start", bus.spi_start, cyc == m_start);
                e_rv = (cyc == m_resp) ? N'(1 << m_sel) : '0;
                chk("rsp_valid", bus.rsp_valid, e_rv);
                chk("rsp_rdata", bus.rsp_rdata, (cyc == m_resp) ? m_rdata : 0);
                chk("rsp_err", bus.rsp_err, (cyc == m_resp) ? m_err : 0);
                if (m_start >= 0 && cyc >= m_start && (pending || cyc <= m_resp)) begin
                    chk("spi_sel", bus.spi_sel, m_sel);
                    chk("spi_wdata", bus.spi_wdata, m_wdata);
                end
                if (pending && cyc >= m_wait_lo) begin
                    if (bus.spi_done) begin
                        m_rdata = bus.spi_rdata; m_err = 1'b0;
                        m_resp = cyc + 1; m_free = m_resp + 1 + GAP; pending = 1'b0;
                    end else if (cyc == m_wait_lo + TO - 1) begin
                        m_rdata = '0; m_err = 1'b1;
                        m_resp = cyc + 1; m_free = m_resp + 1 + GAP; pending = 1'b0;
                    end
                end
                w = -1; e_ready = '0; m_gmask = '0;
                if (e_idle && pll) begin
                    for (int k = 0; k < N; k++)
                        if (w < 0 && bus.req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                    if (w >= 0) begin
                        e_ready[w] = 1'b1;
                        m_gmask    = e_ready;
                        m_sel      = w;
                        m_wdata    = bus.req_wdata[w*DW +: DW];
                        m_ptr      = (w + 1) % N;
                        m_start    = cyc + 1;
                        m_wait_lo  = cyc + 2;
                        m_resp     = -1;
                        pending    = 1'b1;
                    end
                end
                chk("req_ready", bus.req_ready, e_ready);
            end
        end
    end

    // SPI master stand-in: 0 random done pulses, 1 fixed delay after start, 2 silent.
    int rmode = 1;
    int rdly = 3;
    int stray_at = -1;
    initial begin
        bus.spi_done  = 1'b0;
        bus.spi_rdata = '0;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0: begin
                    bus.spi_done  = ($urandom % 8 == 0);
                    bus.spi_rdata = DW'($urandom);
                end
                1: begin
                    bus.spi_done  = (m_start >= 0 && cyc == m_start + rdly) || (cyc == stray_at);
                    bus.spi_rdata = 16'h1234;
                end
                default: bus.spi_done = (cyc == stray_at);
            endcase
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic to_neg(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_ready(output logic [N-1:0] r);
        r = '0;
        for (int n = 0; n < 200 && r == '0; n++) begin
            @(negedge clk);
            r = bus.req_ready;
        end
    endtask

    task automatic wait_rsp(output logic [N-1:0] r);
        r = '0;
        for (int n = 0; n < 300 && r == '0; n++) begin
            @(negedge clk);
            r = bus.rsp_valid;
        end
    endtask

    logic [N-1:0] r, v;
    int g, s, rc, prev;

    initial begin
        bus.req_valid = '0;
        bus.req_wdata = '0;
        repeat (3) step();
        rst = 1'b0;
        pll = 1'b1;

        // Contention from reset: order 0,1,2,0, grants 10 cycles apart.
        bus.req_wdata = {16'h2222, 16'h1111, 16'h0AAA};
        bus.req_valid = 3'b111;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ready(r);
            chk("rr_order", r, 3'b001 << (k % 3));
            if (k > 0) chk("grant_spacing", cyc - prev, 10);
            prev = cyc;
        end
        step();
        bus.req_valid = '0;
        for (int n = 0; n < 100 && busy; n++) @(negedge clk);
        chk("idle_after_contention", busy, 0);

        // Single request with fixed response.
        step();
        bus.req_wdata[0 +: DW] = 16'hA5A5;
        bus.req_valid = 3'b001;
        @(negedge clk);
        chk("t1_ready", bus.req_ready, 3'b001);
        g = cyc;
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk("t1_start", bus.spi_start, 1);
        chk("t1_sel", bus.spi_sel, 0);
        chk("t1_wdata", bus.spi_wdata, 16'hA5A5);
        wait_rsp(r);
        chk("t1_rsp_valid", r, 3'b001);
        chk("t1_rdata", bus.rsp_rdata, 16'h1234);
        chk("t1_err", bus.rsp_err, 0);
        chk("t1_latency", cyc - g, 5);
        rc = cyc;

        // Stray done in GAP, then in IDLE.
        stray_at = rc + 2;
        to_neg(rc + 3);
        chk("stray_gap_busy", busy, 1);
        chk("stray_gap_rsp", bus.rsp_valid, 0);
        to_neg(rc + GAP + 1);
        chk("gap_end_idle", busy, 0);
        stray_at = cyc + 2;
        to_neg(cyc + 3);
        chk("stray_idle_busy", busy, 0);
        chk("stray_idle_rsp", bus.rsp_valid, 0);

        // Timeout.
        rmode = 2;
        step();
        bus.req_wdata[DW +: DW] = 16'hBEEF;
        bus.req_valid = 3'b010;
        wait_ready(r);
        chk("t3_ready", r, 3'b010);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        s = cyc;
        wait_rsp(r);
        chk("t3_rsp_valid", r, 3'b010);
        chk("t3_latency", cyc - s, 51);
        chk("t3_err", bus.rsp_err, 1);
        chk("t3_rdata", bus.rsp_rdata, 0);
        rc = cyc;
        to_neg(rc + GAP);
        chk("t3_gap_busy", busy, 1);
        to_neg(rc + GAP + 1);
        chk("t3_idle", busy, 0);

        // PLL gating.
        rmode = 1;
        step();
        pll = 1'b0;
        bus.req_valid = 3'b010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("pll_low_no_ready", bus.req_ready, 0);
        end
        step();
        pll = 1'b1;
        @(negedge clk);
        chk("pll_high_ready", bus.req_ready, 3'b010);
        step();
        bus.req_valid = '0;
        step();
        pll = 1'b0;
        wait_rsp(r);
        chk("pll_drop_rsp", r, 3'b010);
        step();
        pll = 1'b1;

        // Reset mid-WAIT abandons the transaction and clears rr_ptr.
        rmode = 2;
        bus.req_valid = 3'b010;
        wait_ready(r);
        chk("t5_ready", r, 3'b010);
        step();
        bus.req_valid = 3'b101;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_sel", bus.spi_sel, 0);
        chk("t5_rst_ready", bus.req_ready, 0);
        chk("t5_rst_rsp", bus.rsp_valid, 0);
        chk("t5_rst_start", bus.spi_start, 0);
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_ptr_reset", bus.req_ready, 3'b001);
        rmode = 1;
        step();
        bus.req_valid = '0;
        wait_rsp(r);
        chk("t5_rsp", r, 3'b001);

        // Randomized traffic; a silent phase forces timeouts.
        rmode = 0;
        for (int c = 0; c < 2800; c++) begin
            if (c == 2200) rmode = 2;
            step();
            pll = ($urandom % 16 != 0);
            v = bus.req_valid;
            for (int i = 0; i < N; i++) begin
                if (m_gmask[i]) begin
                    v[i] = $urandom % 2;
                    bus.req_wdata[i*DW +: DW] = DW'($urandom);
                end else if (!v[i]) begin
                    if ($urandom % 4 == 0) begin
                        v[i] = 1'b1;
                        bus.req_wdata[i*DW +: DW] = DW'($urandom);
                    end
                end else if ($urandom % 64 == 0) begin
                    v[i] = 1'b0;
                end
            end
            bus.req_valid = v;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
